// File: rtl/encoder_capture_buffer_if.sv
// Capture-buffer bus: encoder beat input, readback select and status/readback outputs.
// Master drives encoder beats and readback selects; slave is the capture buffer.
interface encoder_capture_buffer_if #(
  parameter int GPIO_LEN        = 32,
  parameter int LEN_CODED_BLOCK = 66,
  parameter int RAM_WIDTH_TYPE  = 4,
  parameter int RAM_ADDR_NBIT   = 5
);
  logic                       i_enable_capture;
  logic                       i_valid;
  logic [LEN_CODED_BLOCK-1:0] i_coded_block;
  logic [RAM_WIDTH_TYPE-1:0]  i_block_type;
  logic [RAM_ADDR_NBIT-1:0]   i_read_address;
  logic [1:0]                 i_slice_sel;
  logic [GPIO_LEN-1:0]        o_read_data;
  logic                       o_busy;
  logic                       o_capture_done;
  logic [RAM_ADDR_NBIT:0]     o_wr_count;

  modport master (
    output i_enable_capture, i_valid, i_coded_block, i_block_type, i_read_address, i_slice_sel,
    input  o_read_data, o_busy, o_capture_done, o_wr_count
  );

  modport slave (
    input  i_enable_capture, i_valid, i_coded_block, i_block_type, i_read_address, i_slice_sel,
    output o_read_data, o_busy, o_capture_done, o_wr_count
  );
endinterface

// File: rtl/encoder_capture_buffer.sv
// Arms on enable rising edge, stores valid 66b blocks + type until full; 1-cycle registered readback.
// No backpressure: beats arriving outside CAPTURE (or on the abort cycle) are dropped.
module encoder_capture_buffer #(
  parameter int GPIO_LEN        = 32,
  parameter int LEN_CODED_BLOCK = 66,
  parameter int RAM_WIDTH_TYPE  = 4,
  parameter int RAM_ADDR_NBIT   = 5
) (
  input logic                     i_clock,
  input logic                     i_reset,
  encoder_capture_buffer_if.slave cap
);
  localparam int DEPTH = 1 << RAM_ADDR_NBIT;
  localparam logic [RAM_ADDR_NBIT:0] LAST_ADDR = (RAM_ADDR_NBIT+1)'(DEPTH - 1);
  localparam logic [RAM_ADDR_NBIT:0] CNT_ONE   = (RAM_ADDR_NBIT+1)'(1);

  typedef struct packed {
    logic [RAM_WIDTH_TYPE-1:0]  blk_type;
    logic [LEN_CODED_BLOCK-1:0] coded;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   enable_d;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   wr_en;
  logic [RAM_ADDR_NBIT:0] wr_count;
  logic [GPIO_LEN-1:0]    read_data;
  entry_t                 ram [DEPTH];
  entry_t                 rd_entry;

  assign start = cap.i_enable_capture & ~enable_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      enable_d <= 1'b0;
    end else begin
      state    <= state_nxt;
      enable_d <= cap.i_enable_capture;
    end
  end

  // Abort outranks the final write so a late enable drop never fills the buffer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!cap.i_enable_capture)                      state_nxt = ST_IDLE;
        else if (cap.i_valid && (wr_count == LAST_ADDR)) state_nxt = ST_DONE;
      end
      ST_DONE:    if (!cap.i_enable_capture) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == ST_CAPTURE);
    done  = (state == ST_DONE);
    wr_en = busy & cap.i_enable_capture & cap.i_valid;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)                         wr_count <= '0;
    else if ((state == ST_IDLE) && start) wr_count <= '0;
    else if (wr_en)                      wr_count <= wr_count + CNT_ONE;
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) ram[wr_count[RAM_ADDR_NBIT-1:0]] <= {cap.i_block_type, cap.i_coded_block};
  end

  // Async array read feeding a registered output gives read-first behaviour on a same-address write.
  assign rd_entry = ram[cap.i_read_address];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      read_data <= '0;
    end else begin
      case (cap.i_slice_sel)
        2'd0:    read_data <= rd_entry.coded[31:0];
        2'd1:    read_data <= rd_entry.coded[63:32];
        2'd2:    read_data <= {{(GPIO_LEN-RAM_WIDTH_TYPE-2){1'b0}}, rd_entry.blk_type,
                               rd_entry.coded[LEN_CODED_BLOCK-1:LEN_CODED_BLOCK-2]};
        default: read_data <= {done, busy, {(GPIO_LEN-RAM_ADDR_NBIT-3){1'b0}}, wr_count};
      endcase
    end
  end

  assign cap.o_read_data    = read_data;
  assign cap.o_busy         = busy;
  assign cap.o_capture_done = done;
  assign cap.o_wr_count     = wr_count;
endmodule

// File: tb/tb_encoder_capture_buffer.sv
// Directed bench for encoder_capture_buffer: reference memory model plus a readback scoreboard queue.
module tb_encoder_capture_buffer;
  logic i_clock = 1'b0;
  logic i_reset;
  always #5 i_clock = ~i_clock;

  encoder_capture_buffer_if bus ();

  encoder_capture_buffer dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .cap     (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [65:0] m_coded [32];
  logic [3:0]  m_type  [32];
  logic [31:0] sb_q [$];
  logic [31:0] popped;
  int          cnt;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int a, input logic [65:0] c, input logic [3:0] t);
    m_coded[a] = c;
    m_type[a]  = t;
  endtask

  function automatic logic [31:0] exp_slice(input int a, input logic [1:0] s);
    case (s)
      2'd0:    return m_coded[a][31:0];
      2'd1:    return m_coded[a][63:32];
      default: return {26'b0, m_type[a], m_coded[a][65:64]};
    endcase
  endfunction

  task automatic beat(input logic v, input logic [65:0] c, input logic [3:0] t);
    bus.i_valid       = v;
    bus.i_coded_block = c;
    bus.i_block_type  = t;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [1:0] s,
                            input logic [31:0] exp);
    bus.i_valid        = 1'b0;
    bus.i_read_address = a;
    bus.i_slice_sel    = s;
    sb_q.push_back(exp);
    tick();
    popped = sb_q.pop_front();
    check(tag, bus.o_read_data, popped);
  endtask

  initial begin
    i_reset              = 1'b1;
    bus.i_enable_capture = 1'b0;
    bus.i_read_address   = '0;
    bus.i_slice_sel      = '0;
    beat(1'b0, '0, '0);
    tick();
    tick();
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_done", 32'(bus.o_capture_done), 32'd0);
    check("reset_wr_count", 32'(bus.o_wr_count), 32'd0);
    check("reset_read_data", bus.o_read_data, 32'd0);
    i_reset = 1'b0;

    // Full capture with continuous valid
    bus.i_enable_capture = 1'b1;
    tick();
    check("full_start_busy", 32'(bus.o_busy), 32'd1);
    for (int i = 0; i < 32; i++) begin
      beat(1'b1, 66'(i), 4'(i % 16));
      tick();
      model_write(i, 66'(i), 4'(i % 16));
      if (i == 30) begin
        check("full_not_done_at_31", 32'(bus.o_capture_done), 32'd0);
        check("full_count_31", 32'(bus.o_wr_count), 32'd31);
      end
    end
    check("full_done", 32'(bus.o_capture_done), 32'd1);
    check("full_busy_fell", 32'(bus.o_busy), 32'd0);
    check("full_wr_count", 32'(bus.o_wr_count), 32'd32);
    read_check("full_addr5_s0", 5'd5, 2'd0, 32'h0000_0005);
    read_check("full_addr5_s2", 5'd5, 2'd2, 32'h0000_0014);
    read_check("full_status", 5'd0, 2'd3, 32'h8000_0020);
    read_check("full_addr31_s0", 5'd31, 2'd0, exp_slice(31, 2'd0));

    // Enable held through DONE with valid still arriving
    for (int k = 0; k < 50; k++) begin
      beat(1'b1, {2'b11, 32'hDEAD_0000 | 32'(k), 32'hBEEF_0000 | 32'(k)}, 4'hF);
      tick();
      check("hold_done", 32'(bus.o_capture_done), 32'd1);
    end
    check("hold_wr_count", 32'(bus.o_wr_count), 32'd32);
    read_check("hold_entry0_s0", 5'd0, 2'd0, exp_slice(0, 2'd0));
    read_check("hold_entry0_s2", 5'd0, 2'd2, exp_slice(0, 2'd2));
    bus.i_enable_capture = 1'b0;
    tick();
    check("done_release", 32'(bus.o_capture_done), 32'd0);
    check("done_release_count", 32'(bus.o_wr_count), 32'd32);

    // Gapped valid
    bus.i_enable_capture = 1'b1;
    tick();
    check("gap_start_count", 32'(bus.o_wr_count), 32'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      beat((k % 2) == 0, {2'b01, 32'hA5A5_0000 | 32'(k), 32'h0000_0100 + 32'(k)}, 4'(k + 3));
      tick();
      if ((k % 2) == 0) begin
        model_write(cnt, {2'b01, 32'hA5A5_0000 | 32'(k), 32'h0000_0100 + 32'(k)}, 4'(k + 3));
        cnt++;
      end
    end
    check("gap_wr_count", 32'(bus.o_wr_count), 32'd20);
    check("gap_busy", 32'(bus.o_busy), 32'd1);
    read_check("gap_e0_s0", 5'd0, 2'd0, exp_slice(0, 2'd0));
    read_check("gap_e0_s1", 5'd0, 2'd1, exp_slice(0, 2'd1));
    read_check("gap_e0_s2", 5'd0, 2'd2, exp_slice(0, 2'd2));
    read_check("gap_e10_s0", 5'd10, 2'd0, exp_slice(10, 2'd0));
    read_check("gap_e19_s0", 5'd19, 2'd0, exp_slice(19, 2'd0));
    read_check("gap_e19_s2", 5'd19, 2'd2, exp_slice(19, 2'd2));

    // Abort after 10 writes, then re-arm
    bus.i_enable_capture = 1'b0;
    tick();
    check("gap_abort_busy", 32'(bus.o_busy), 32'd0);
    bus.i_enable_capture = 1'b1;
    tick();
    check("rearm_count_zero", 32'(bus.o_wr_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, {2'b10, 32'h0, 32'hC000_0000 + 32'(i)}, 4'(i));
      tick();
      model_write(i, {2'b10, 32'h0, 32'hC000_0000 + 32'(i)}, 4'(i));
    end
    bus.i_enable_capture = 1'b0;
    beat(1'b1, {2'b11, 64'hFFFF_FFFF_FFFF_FFFF}, 4'hE);
    bus.i_read_address   = 5'd0;
    bus.i_slice_sel      = 2'd3;
    sb_q.push_back(32'h4000_000A);
    tick();
    popped = sb_q.pop_front();
    check("abort_status_pre_edge", bus.o_read_data, popped);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_wr_count", 32'(bus.o_wr_count), 32'd10);
    read_check("abort_status", 5'd0, 2'd3, 32'h0000_000A);
    read_check("abort_e10_untouched", 5'd10, 2'd0, exp_slice(10, 2'd0));
    bus.i_enable_capture = 1'b1;
    tick();
    check("rearm2_count_zero", 32'(bus.o_wr_count), 32'd0);
    check("rearm2_busy", 32'(bus.o_busy), 32'd1);

    // Read-first on a same-address write
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 66'(200 + i), 4'h1);
      tick();
      model_write(i, 66'(200 + i), 4'h1);
    end
    beat(1'b1, 66'h0_0000_ABCD_1234_5678, 4'h6);
    bus.i_read_address = 5'd3;
    bus.i_slice_sel    = 2'd0;
    sb_q.push_back(exp_slice(3, 2'd0));
    tick();
    popped = sb_q.pop_front();
    check("read_first_old", bus.o_read_data, popped);
    model_write(3, 66'h0_0000_ABCD_1234_5678, 4'h6);
    read_check("read_after_s0", 5'd3, 2'd0, 32'h1234_5678);
    read_check("read_after_s1", 5'd3, 2'd1, 32'h0000_ABCD);
    read_check("read_after_s2", 5'd3, 2'd2, 32'h0000_0018);

    // Abort coinciding with the 32nd write
    for (int i = 4; i < 31; i++) begin
      beat(1'b1, 66'(500 + i), 4'(i));
      tick();
      model_write(i, 66'(500 + i), 4'(i));
    end
    check("pre32_count", 32'(bus.o_wr_count), 32'd31);
    check("pre32_busy", 32'(bus.o_busy), 32'd1);
    bus.i_enable_capture = 1'b0;
    beat(1'b1, {2'b10, 64'h5555_5555_5555_5555}, 4'h9);
    tick();
    check("abort32_busy", 32'(bus.o_busy), 32'd0);
    check("abort32_done", 32'(bus.o_capture_done), 32'd0);
    check("abort32_count", 32'(bus.o_wr_count), 32'd31);
    read_check("abort32_e31", 5'd31, 2'd0, exp_slice(31, 2'd0));
    read_check("abort32_e30", 5'd30, 2'd0, exp_slice(30, 2'd0));

    // Reset in the middle of a capture
    bus.i_enable_capture = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 66'(900 + i), 4'h2);
      tick();
    end
    check("mid_count_3", 32'(bus.o_wr_count), 32'd3);
    i_reset = 1'b1;
    tick();
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_count", 32'(bus.o_wr_count), 32'd0);
    check("midrst_read_data", bus.o_read_data, 32'd0);
    i_reset              = 1'b0;
    bus.i_enable_capture = 1'b0;
    beat(1'b0, '0, '0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
